// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and default widths for the memory request controller
package mem_ctrl_pkg;

  localparam int DEF_ADDR_WID   = 5;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } ctrl_state_t;

  typedef struct packed {
    logic                      wr;
    logic [DEF_ADDR_WID-1:0]   addr;
    logic [DEF_DATA_WIDTH-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/req_fifo.sv
// rtl/req_fifo.sv - in-order request queue with wrap-bit full/empty decode
module req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so equal low bits mean full or empty.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = storage[rd_ptr[AW-1:0]];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) storage[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// rtl/mem_req_ctrl.sv - clears memory after reset, then serialises queued requests onto simple_mem
module mem_req_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WID   = DEF_ADDR_WID,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WID-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  output logic [ADDR_WID-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  init_busy
);

  localparam int ENTRY_W = 1 + ADDR_WID + DATA_WIDTH;

  ctrl_state_t          state;
  logic [ADDR_WID-1:0]  sweep_addr;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic [ENTRY_W-1:0]   push_data;
  logic [ENTRY_W-1:0]   pop_data;
  logic                 rd_sampled;

  assign req_ready = (state == RUN) && !fifo_full;
  assign init_busy = (state == INIT);
  assign push      = req_valid && req_ready;
  assign pop       = (state == RUN) && !fifo_empty;
  assign push_data = {req_wr, req_addr, req_wdata};

  req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_req_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= INIT;
      sweep_addr  <= '0;
      mem_wr_en   <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
    end else if (state == INIT) begin
      mem_wr_en   <= 1'b1;
      mem_rd_en   <= 1'b0;
      mem_addr    <= sweep_addr;
      mem_data_in <= '0;
      sweep_addr  <= sweep_addr + 1'b1;
      if (sweep_addr == {ADDR_WID{1'b1}}) state <= RUN;
    end else if (pop) begin
      mem_wr_en   <= pop_data[ENTRY_W-1];
      mem_rd_en   <= !pop_data[ENTRY_W-1];
      mem_addr    <= pop_data[ENTRY_W-2 -: ADDR_WID];
      mem_data_in <= pop_data[DATA_WIDTH-1:0];
    end else begin
      // Address and data hold so the memory bus only toggles on real accesses.
      mem_wr_en <= 1'b0;
      mem_rd_en <= 1'b0;
    end
  end

  // The memory samples rd_en one edge after issue and presents data the edge after that.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_sampled <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
    end else begin
      rd_sampled <= mem_rd_en;
      rsp_valid  <= rd_sampled;
      if (rd_sampled) rsp_data <= mem_data_out;
    end
  end

endmodule
